// File: rtl/hsv_mixer_multi.sv
// Multi-channel quadrature-encoder colour mixer: each channel debounces its encoder,
// steps a level register, and drives a PWM whose duty only changes at period wrap.
module hsv_mixer_multi #(
  parameter int NUM_CH     = 3,
  parameter int VAL_W      = 8,
  parameter int STEP       = 1,
  parameter int DEB_CYCLES = 4,
  parameter int WRAP       = 0,
  parameter int INIT_VAL   = 0,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic [NUM_CH-1:0] pwm_out,
  input  logic [SEL_W-1:0]  sel,
  output logic [VAL_W-1:0]  level_out,
  output logic [NUM_CH-1:0] step_pulse
);

  localparam logic [VAL_W-1:0] MAX_VAL  = {VAL_W{1'b1}};
  localparam logic [VAL_W-1:0] INIT_V   = VAL_W'(INIT_VAL);
  localparam logic [VAL_W:0]   STEP_W   = (VAL_W+1)'(STEP);
  localparam logic [7:0]       DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [VAL_W-1:0]        pwm_cnt_q;
  logic                    pwm_wrap;
  logic [NUM_CH*VAL_W-1:0] level_flat;
  logic [VAL_W-1:0]        sel_level;
  logic [VAL_W-1:0]        level_out_q;

  assign pwm_wrap = (pwm_cnt_q == MAX_VAL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  genvar gi, gb;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [1:0]       pin_w;
    logic [1:0]       filt_w;
    logic             a_prev_q;
    logic             detent;
    logic [VAL_W:0]   sum_w;
    logic [VAL_W-1:0] level_q, level_d;
    logic [VAL_W-1:0] duty_q;
    logic             pwm_q;
    logic             step_q;

    assign pin_w = {enc_b[gi], enc_a[gi]};

    // bit 0 = A, bit 1 = B; each goes sync -> debounce independently
    for (gb = 0; gb < 2; gb++) begin : g_bit
      logic       s1_q, s2_q, filt_q, filt_d;
      logic [7:0] cnt_q, cnt_d;

      always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
          if (cnt_q == DEB_LAST) begin
            filt_d = s2_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          s1_q   <= 1'b0;
          s2_q   <= 1'b0;
          filt_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          s1_q   <= pin_w[gb];
          s2_q   <= s1_q;
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign filt_w[gb] = filt_q;
    end

    assign detent = filt_w[0] & ~a_prev_q;

    // one extra bit catches both overflow and borrow
    always_comb begin
      sum_w   = filt_w[1] ? ({1'b0, level_q} - STEP_W) : ({1'b0, level_q} + STEP_W);
      level_d = level_q;
      if (detent) begin
        if (WRAP != 0) begin
          level_d = sum_w[VAL_W-1:0];
        end else if (sum_w[VAL_W]) begin
          level_d = filt_w[1] ? '0 : MAX_VAL;
        end else begin
          level_d = sum_w[VAL_W-1:0];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        a_prev_q <= 1'b0;
        level_q  <= INIT_V;
        duty_q   <= INIT_V;
        pwm_q    <= 1'b0;
        step_q   <= 1'b0;
      end else begin
        a_prev_q <= filt_w[0];
        level_q  <= level_d;
        step_q   <= detent;
        pwm_q    <= (pwm_cnt_q < duty_q);
        if (pwm_wrap) begin
          duty_q <= level_q;
        end
      end
    end

    assign level_flat[gi*VAL_W +: VAL_W] = level_q;
    assign pwm_out[gi]    = pwm_q;
    assign step_pulse[gi] = step_q;
  end

  always_comb begin
    sel_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(sel) == i) begin
        sel_level = level_flat[i*VAL_W +: VAL_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_out_q <= '0;
    end else begin
      level_out_q <= sel_level;
    end
  end

  assign level_out = level_out_q;

endmodule
